// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the pixel-clock PLL reconfiguration sequencer.
// Contents:
//   - Avalon-MM register addresses of the PLL reconfiguration core
//   - pll_preset_t: M, N and C0 divide values for one video mode
//   - PRESET_TABLE: the four supported video-mode presets (50 MHz reference)
//   - enc_cnt(): builds the 32-bit counter word the reconfig core expects
//   - state_t: sequencer FSM states
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;

    localparam int NUM_PRESETS = 4;

    typedef struct packed {
        logic [8:0] m;
        logic [8:0] n;
        logic [8:0] c;
    } pll_preset_t;

    // 0: 162 MHz, 1: 148.5 MHz, 2: 108 MHz, 3: 65 MHz
    localparam pll_preset_t PRESET_TABLE [NUM_PRESETS] = '{
        '{m: 9'd81,  n: 9'd5,  c: 9'd5},
        '{m: 9'd297, n: 9'd20, c: 9'd5},
        '{m: 9'd108, n: 9'd5,  c: 9'd10},
        '{m: 9'd13,  n: 9'd1,  c: 9'd10}
    };

    // Counter word: [22:18] counter select, [17] odd, [16] bypass,
    // [15:8] high count, [7:0] low count. A divide of 1 uses bypass.
    function automatic logic [31:0] enc_cnt(input logic [8:0] d, input logic [4:0] sel);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(({1'b0, d} + 10'd1) >> 1);
        lo = 8'(d >> 1);
        if (d == 9'd1) begin
            return 32'h0001_0101;
        end
        return {9'd0, sel, d[0], 1'b0, hi, lo};
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C0,
        ST_WR_START,
        ST_LOCK,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/pll_reconfig_seq_lock_mon.sv
// pll_lock_mon: lock qualification for an asynchronous PLL lock signal.
// Ports:
//   clk        - local clock
//   reset_n    - asynchronous active-low reset
//   lock_async - raw PLL lock, asynchronous to clk
//   clr        - holds the stability count at zero while high
//   lock_sync  - lock after a 2-flop synchronizer
//   stable     - high once lock_sync has been high LOCK_STABLE consecutive
//                cycles with clr low
module pll_lock_mon #(
    parameter int LOCK_STABLE = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic lock_async,
    input  logic clr,
    output logic lock_sync,
    output logic stable
);

    localparam int CW = $clog2(LOCK_STABLE + 1);
    localparam logic [CW-1:0] STABLE_CNT = CW'(LOCK_STABLE);

    logic          lock_meta;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= lock_async;
            lock_sync <= lock_meta;
        end
    end

    // Any low cycle of the synchronized lock restarts the count; the count
    // saturates so stable stays asserted while lock holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || !lock_sync) begin
            cnt <= '0;
        end else if (cnt != STABLE_CNT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stable = (cnt == STABLE_CNT);

endmodule

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: retunes the pixel-clock PLL through the reconfig core's
// Avalon-MM management port and gates the pixel pipeline until lock is stable.
// Ports:
//   clk, reset_n          - management clock, asynchronous active-low reset
//   cfg_start, cfg_mode   - request pulse and preset index (0..3 valid)
//   cfg_busy              - sequence in progress
//   cfg_done              - one-cycle pulse at the end of every sequence
//   cfg_err               - sticky error, cleared by the next accepted request
//   pix_en                - pixel clock valid
//   pll_locked            - raw PLL lock (asynchronous)
//   mgmt_address/_write/_writedata/_waitrequest - Avalon-MM master
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic [2:0]  cfg_mode,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        pix_en,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(LOCK_TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    pll_preset_t     preset;
    logic [TW-1:0]   tcnt;
    logic            timeout_hit;
    logic            accept;
    logic            lock_sync;
    logic            lock_stable;

    assign accept      = (state == ST_IDLE) && cfg_start;
    assign timeout_hit = (tcnt == TIMEOUT_CNT);

    pll_lock_mon #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_mon (
        .clk       (clk),
        .reset_n   (reset_n),
        .lock_async(pll_locked),
        .clr       (state != ST_LOCK),
        .lock_sync (lock_sync),
        .stable    (lock_stable)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Preset is only presented on the bus in WR_* states, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            preset <= PRESET_TABLE[cfg_mode[1:0]];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_mode > 3'd3) ? ST_FAIL : ST_WR_MODE;
                end
            end
            ST_WR_MODE:  if (!mgmt_waitrequest) state_nxt = ST_WR_N;
            ST_WR_N:     if (!mgmt_waitrequest) state_nxt = ST_WR_M;
            ST_WR_M:     if (!mgmt_waitrequest) state_nxt = ST_WR_C0;
            ST_WR_C0:    if (!mgmt_waitrequest) state_nxt = ST_WR_START;
            ST_WR_START: if (!mgmt_waitrequest) state_nxt = ST_LOCK;
            ST_LOCK: begin
                if (lock_stable) begin
                    state_nxt = ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_DONE:     state_nxt = ST_IDLE;
            ST_FAIL:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs decode straight from state so an asynchronous reset drops
    // mgmt_write without waiting for a clock.
    always_comb begin
        mgmt_write     = 1'b0;
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        case (state)
            ST_WR_MODE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_MODE;
                mgmt_writedata = 32'd0;
            end
            ST_WR_N: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_N;
                mgmt_writedata = enc_cnt(preset.n, 5'd0);
            end
            ST_WR_M: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_M;
                mgmt_writedata = enc_cnt(preset.m, 5'd0);
            end
            ST_WR_C0: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_C;
                mgmt_writedata = enc_cnt(preset.c, 5'd0);
            end
            ST_WR_START: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_START;
                mgmt_writedata = 32'd1;
            end
            default: begin
                mgmt_write     = 1'b0;
            end
        endcase
    end

    // Timeout runs from WR_START entry through LOCK and saturates; only
    // LOCK acts on it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (state == ST_WR_START || state == ST_LOCK) begin
            if (!timeout_hit) begin
                tcnt <= tcnt + 1'b1;
            end
        end else begin
            tcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            pix_en   <= 1'b0;
        end else begin
            cfg_busy <= (state_nxt != ST_IDLE);
            cfg_done <= (state == ST_DONE) || (state == ST_FAIL);
            if (accept) begin
                cfg_err <= 1'b0;
            end else if (state == ST_FAIL) begin
                cfg_err <= 1'b1;
            end
            // Losing lock while idle drops the pixel enable; no retune follows.
            if (accept) begin
                pix_en <= 1'b0;
            end else if (state == ST_DONE) begin
                pix_en <= 1'b1;
            end else if (state == ST_IDLE && !lock_sync) begin
                pix_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: scoreboard of expected Avalon
// writes and sequence completions, randomized modes, stalls and lock behaviour.
module tb_pll_reconfig_seq;

    localparam int LS = 1024;
    localparam int TO = 3000;

    logic        clk;
    logic        reset_n;
    logic        cfg_start;
    logic [2:0]  cfg_mode;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        pix_en;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    pll_reconfig_seq #(
        .LOCK_STABLE (LS),
        .LOCK_TIMEOUT(TO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_start       (cfg_start),
        .cfg_mode        (cfg_mode),
        .cfg_busy        (cfg_busy),
        .cfg_done        (cfg_done),
        .cfg_err         (cfg_err),
        .pix_en          (pix_en),
        .pll_locked      (pll_locked),
        .mgmt_address    (mgmt_address),
        .mgmt_write      (mgmt_write),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest)
    );

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int   cyc;
        logic err;
    } done_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    int    wait_q[$];
    int    wt[5];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_done = 0;
    int    cyc = 0;

    // Expected counter words, per preset, taken from the mode table.
    logic [31:0] exp_n [4] = '{32'h20302, 32'h00A0A, 32'h20302, 32'h10101};
    logic [31:0] exp_m [4] = '{32'h22928, 32'h29594, 32'h03636, 32'h20706};
    logic [31:0] exp_c [4] = '{32'h20302, 32'h20302, 32'h00505, 32'h00505};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reconfig-core model: stalls each write by the number queued for it.
    initial begin
        int stall;
        stall = 0;
        mgmt_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                mgmt_waitrequest = 1'b0;
                stall = 0;
            end else if (mgmt_write && wait_q.size() > 0) begin
                if (stall < wait_q[0]) begin
                    mgmt_waitrequest = 1'b1;
                    stall = stall + 1;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    stall = 0;
                    void'(wait_q.pop_front());
                end
            end else begin
                mgmt_waitrequest = 1'b0;
            end
        end
    end

    // Monitor: compares every bus cycle and every completion with the scoreboard.
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (mgmt_write) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_addr", {26'd0, mgmt_address}, 32'hFFFF_FFFF);
                end else begin
                    chk("write_addr", {26'd0, mgmt_address}, {26'd0, wr_q[0].a});
                    chk("write_data", mgmt_writedata, wr_q[0].d);
                    if (!mgmt_waitrequest) void'(wr_q.pop_front());
                end
            end
            if (cfg_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("done_cycle", cyc, done_q[0].cyc);
                    chk("done_err", {31'd0, cfg_err}, {31'd0, done_q[0].err});
                    chk("done_pix_en", {31'd0, pix_en}, {31'd0, !done_q[0].err});
                    chk("done_busy", {31'd0, cfg_busy}, 32'd0);
                    chk("writes_drained", wr_q.size(), 32'd0);
                    void'(done_q.pop_front());
                end
                n_done = n_done + 1;
            end
        end
    end

    // lk: 0 lock held high, 1 low for glen cycles gofs after LOCK entry, 2 never locks
    task automatic run_seq(input int mode, input int lk, input int gofs, input int glen, input bit poke);
        int    c, w_all, l_ent, e_ent, n0, start_done;
        done_t de;
        bit    valid;
        valid = (mode <= 3);
        n0 = -100;
        @(posedge clk);
        #1;
        c = cyc;
        cfg_start = 1'b1;
        cfg_mode  = 3'(mode);
        if (valid) begin
            wr_q.push_back('{a: 6'h00, d: 32'd0});
            wr_q.push_back('{a: 6'h03, d: exp_n[mode]});
            wr_q.push_back('{a: 6'h04, d: exp_m[mode]});
            wr_q.push_back('{a: 6'h05, d: exp_c[mode]});
            wr_q.push_back('{a: 6'h02, d: 32'd1});
            w_all = 0;
            for (int i = 0; i < 5; i++) begin
                wait_q.push_back(wt[i]);
                w_all += wt[i] + 1;
            end
            l_ent = c + 1 + w_all;
            e_ent = l_ent - (wt[4] + 1);
            if (lk == 0) begin
                de = '{cyc: c + w_all + LS + 3, err: 1'b0};
            end else if (lk == 1) begin
                n0 = l_ent + gofs;
                de = '{cyc: n0 + glen + LS + 4, err: 1'b0};
            end else begin
                de = '{cyc: e_ent + TO + 2, err: 1'b1};
            end
        end else begin
            de = '{cyc: c + 2, err: 1'b1};
        end
        done_q.push_back(de);
        start_done = n_done;
        for (int k = 0; k < TO + LS + 200; k++) begin
            @(posedge clk);
            #1;
            cfg_start = 1'b0;
            if (lk == 2 && valid) pll_locked = 1'b0;
            else if (lk == 1 && cyc >= n0 && cyc < n0 + glen) pll_locked = 1'b0;
            else pll_locked = 1'b1;
            if (poke && valid && cyc == c + 20) begin
                cfg_start = 1'b1;
                cfg_mode  = 3'($urandom_range(0, 7));
            end
            if (n_done != start_done) break;
        end
        if (n_done == start_done) chk("done_timeout", 32'd0, 32'd1);
        cfg_start  = 1'b0;
        pll_locked = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        cfg_start  = 1'b0;
        cfg_mode   = 3'd0;
        pll_locked = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, cfg_busy},   32'd0);
        chk("rst_done",  {31'd0, cfg_done},   32'd0);
        chk("rst_err",   {31'd0, cfg_err},    32'd0);
        chk("rst_pix",   {31'd0, pix_en},     32'd0);
        chk("rst_write", {31'd0, mgmt_write}, 32'd0);
        chk("rst_addr",  {26'd0, mgmt_address}, 32'd0);
        chk("rst_data",  mgmt_writedata,      32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Mode 0, no stalls, lock steady; a second request while busy is ignored.
        wt = '{0, 0, 0, 0, 0};
        run_seq(0, 0, 0, 0, 1'b1);

        // Lock drop while idle clears pix_en within 3 cycles, no new sequence.
        begin
            int n;
            @(posedge clk);
            #1;
            n = cyc;
            pll_locked = 1'b0;
            while (cyc < n + 2) begin
                @(posedge clk);
                #1;
            end
            chk("pix_hold_before_sync", {31'd0, pix_en}, 32'd1);
            @(posedge clk);
            #1;
            chk("pix_drop_3cyc", {31'd0, pix_en}, 32'd0);
            repeat (10) @(posedge clk);
            #1;
            chk("no_resequence_busy", {31'd0, cfg_busy}, 32'd0);
            pll_locked = 1'b1;
            repeat (4) @(posedge clk);
        end

        // Mode 3 with START stalled 7 cycles.
        wt = '{0, 0, 0, 0, 7};
        run_seq(3, 0, 0, 0, 1'b0);

        // Mode 1, lock glitch at stability count 500.
        wt = '{0, 0, 0, 0, 0};
        run_seq(1, 1, 498, 1, 1'b0);

        // Lock never asserted -> timeout error, then mode 2 clears it.
        wt = '{1, 0, 2, 0, 0};
        run_seq(0, 2, 0, 0, 1'b0);
        chk("err_sticky", {31'd0, cfg_err}, 32'd1);
        wt = '{0, 0, 0, 0, 0};
        run_seq(2, 0, 0, 0, 1'b0);
        chk("err_cleared", {31'd0, cfg_err}, 32'd0);

        // Invalid mode: error after 2 cycles, no bus traffic.
        run_seq(6, 0, 0, 0, 1'b0);

        // Reset asserted in the middle of the M write.
        begin
            int c;
            wt = '{0, 0, 6, 0, 0};
            @(posedge clk);
            #1;
            c = cyc;
            cfg_start = 1'b1;
            cfg_mode  = 3'd0;
            wr_q.push_back('{a: 6'h00, d: 32'd0});
            wr_q.push_back('{a: 6'h03, d: exp_n[0]});
            wr_q.push_back('{a: 6'h04, d: exp_m[0]});
            for (int i = 0; i < 5; i++) wait_q.push_back(wt[i]);
            @(posedge clk);
            #1;
            cfg_start = 1'b0;
            while (cyc < c + 5) begin
                @(posedge clk);
                #1;
            end
            chk("pre_rst_in_wr_m", {26'd0, mgmt_address}, 32'h04);
            #1;
            reset_n = 1'b0;
            #1;
            chk("arst_write", {31'd0, mgmt_write}, 32'd0);
            chk("arst_addr",  {26'd0, mgmt_address}, 32'd0);
            chk("arst_data",  mgmt_writedata, 32'd0);
            chk("arst_busy",  {31'd0, cfg_busy}, 32'd0);
            chk("arst_done",  {31'd0, cfg_done}, 32'd0);
            chk("arst_err",   {31'd0, cfg_err}, 32'd0);
            chk("arst_pix",   {31'd0, pix_en}, 32'd0);
            wr_q.delete();
            wait_q.delete();
            repeat (2) @(posedge clk);
            #1;
            reset_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk("post_rst_write", {31'd0, mgmt_write}, 32'd0);
            chk("post_rst_busy",  {31'd0, cfg_busy}, 32'd0);
        end
        wt = '{0, 0, 0, 0, 0};
        run_seq(0, 0, 0, 0, 1'b0);

        // Randomized sequences.
        for (int r = 0; r < 8; r++) begin
            int mode, lk;
            mode = $urandom_range(0, 4);
            if (mode == 4) mode = $urandom_range(4, 7);
            lk = $urandom_range(0, 1);
            for (int i = 0; i < 5; i++) wt[i] = $urandom_range(0, 3);
            run_seq(mode, lk, $urandom_range(0, 800), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        chk("scoreboard_writes_empty", wr_q.size(), 32'd0);
        chk("scoreboard_done_empty", done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
